gearbox_param: RTL and testbench

//  Generic width converter between any DIN_W-bit and DOUT_W-bit word streams.

---
 rtl/pcs_pkg.sv | 30 +++
 rtl/gb_bit_shifter.sv | 24 ++
 rtl/gearbox_param.sv | 77 +++++++
 tb/tb_gearbox_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared helpers for the PCS datapath blocks: bit-width math and the
// shift selection used by the gearbox residue buffer.
package pcs_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cap_bits(input int din_w, input int dout_w);
        return din_w + dout_w;
    endfunction

    function automatic int fill_bits(input int din_w, input int dout_w);
        return clog2(cap_bits(din_w, dout_w) + 1);
    endfunction

    // bit 1: remove one output word, bit 0: drop one slipped bit
    typedef enum logic [1:0] {
        SH_NONE      = 2'b00,
        SH_SLIP      = 2'b01,
        SH_WORD      = 2'b10,
        SH_WORD_SLIP = 2'b11
    } shift_sel_e;

endpackage

// File: rtl/gb_bit_shifter.sv
// Right shift of the residue buffer by 0, 1, STEP or STEP+1 bits; the word
// removal is applied before the slip drop.
module gb_bit_shifter
    import pcs_pkg::*;
#(
    parameter int W    = 98,
    parameter int STEP = 32
) (
    input  logic [W-1:0] data_i,
    input  shift_sel_e   sel_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] word_sh;

    always_comb begin
        word_sh = data_i;
        data_o  = data_i;
        if (sel_i == SH_WORD || sel_i == SH_WORD_SLIP) word_sh = data_i >> STEP;
        data_o = word_sh;
        if (sel_i == SH_SLIP || sel_i == SH_WORD_SLIP) data_o = word_sh >> 1;
    end

endmodule

// File: rtl/gearbox_param.sv
// DIN_W -> DOUT_W word stream converter with LSB-first residue buffer,
// valid/ready on both sides and a one-deep pending bit-slip.
module gearbox_param
    import pcs_pkg::*;
#(
    parameter int DIN_W  = 66,
    parameter int DOUT_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              slip,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam int CAP    = cap_bits(DIN_W, DOUT_W);
    localparam int FILL_W = fill_bits(DIN_W, DOUT_W);
    localparam logic [FILL_W-1:0] DIN_F  = FILL_W'(DIN_W);
    localparam logic [FILL_W-1:0] DOUT_F = FILL_W'(DOUT_W);
    localparam logic [FILL_W-1:0] ONE_F  = FILL_W'(1);

    logic [CAP-1:0]    sbuf_q, sbuf_d, shifted, din_ext;
    logic [FILL_W-1:0] fill_q, fill_d, fill_rm, fill_sl;
    logic              pend_q, pend_d;
    logic              in_xfer, out_xfer, slip_go;
    shift_sel_e        sel;

    // Handshake outputs look only at registered state, never at the peer's strobes.
    always_comb begin
        din_ready  = (fill_q <= DOUT_F);
        dout_valid = (fill_q >= DOUT_F);
        dout       = sbuf_q[DOUT_W-1:0];
    end

    always_comb begin
        in_xfer  = din_valid & din_ready;
        out_xfer = dout_valid & dout_ready;
        fill_rm  = out_xfer ? (fill_q - DOUT_F) : fill_q;
        slip_go  = pend_q & (fill_rm != '0);
        fill_sl  = slip_go ? (fill_rm - ONE_F) : fill_rm;
        sel      = shift_sel_e'({out_xfer, slip_go});
    end

    gb_bit_shifter #(
        .W    (CAP),
        .STEP (DOUT_W)
    ) u_shift (
        .data_i (sbuf_q),
        .sel_i  (sel),
        .data_o (shifted)
    );

    // Bits at or above fill are always zero, so the append can simply OR in.
    always_comb begin
        din_ext = CAP'(din) << fill_sl;
        sbuf_d  = in_xfer ? (shifted | din_ext) : shifted;
        fill_d  = in_xfer ? (fill_sl + DIN_F) : fill_sl;
        pend_d  = slip_go ? 1'b0 : (pend_q | slip);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sbuf_q <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
        end else begin
            sbuf_q <= sbuf_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_gearbox_param.sv
// Scoreboard bench: four gearbox instances (66->32, 32->66, 8->10, 40->40)
// checked bit-exact against the accepted input bitstream.
module tb_gearbox_param;

    localparam int MW = 128;

    function automatic int di_of(input int g);
        case (g)
            0: return 66;
            1: return 32;
            2: return 8;
            default: return 40;
        endcase
    endfunction

    function automatic int do_of(input int g);
        case (g)
            0: return 32;
            1: return 66;
            2: return 10;
            default: return 40;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic [3:0]    arst_a, din_valid_a, dout_ready_a, slip_a;
    logic [MW-1:0] din_a [4];
    wire  [3:0]    dv_w, dr_w;
    wire  [MW-1:0] dout_w [4];

    int n_chk = 0, n_pass = 0;
    logic last_dr, last_dv, last_acc;
    int k, base;

    int tr_dr2[10] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    int tr_dv2[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    for (genvar G = 0; G < 4; G++) begin : g_dut
        localparam int DI   = di_of(G);
        localparam int DO   = do_of(G);
        localparam int DROP = (G == 2) ? 30 : -1;

        gearbox_param #(.DIN_W(DI), .DOUT_W(DO)) u_dut (
            .clk        (clk),
            .arst       (arst_a[G]),
            .din        (din_a[G][DI-1:0]),
            .din_valid  (din_valid_a[G]),
            .din_ready  (dr_w[G]),
            .slip       (slip_a[G]),
            .dout       (dout_w[G][DO-1:0]),
            .dout_valid (dv_w[G]),
            .dout_ready (dout_ready_a[G])
        );
        assign dout_w[G][MW-1:DO] = '0;

        bit            q[$];
        int            bit_idx = 0;
        int            out_cnt = 0;
        int            qsz = 0;
        logic [MW-1:0] expw;

        // Pop before push: an output word only ever holds bits accepted earlier.
        always @(negedge clk) begin
            if (!arst_a[G]) begin
                q.delete();
                bit_idx = 0;
            end else begin
                if (dv_w[G] && dout_ready_a[G]) begin
                    chk($sformatf("g%0d_sb_avail", G), MW'(q.size() >= DO), MW'(1));
                    if (q.size() >= DO) begin
                        expw = '0;
                        for (int i = 0; i < DO; i++) expw[i] = q.pop_front();
                        chk($sformatf("g%0d_dout_word%0d", G, out_cnt), dout_w[G], expw);
                        out_cnt++;
                    end
                end
                if (din_valid_a[G] && dr_w[G]) begin
                    for (int i = 0; i < DI; i++) begin
                        if (bit_idx != DROP) q.push_back(din_a[G][i]);
                        bit_idx++;
                    end
                end
            end
            qsz = q.size();
        end
    end

    function automatic logic [MW-1:0] pat(input int n);
        logic [31:0] u;
        u = 32'(n);
        return {u ^ 32'h5A5A_0001, u * 32'h9E37_79B9, ~u, u};
    endfunction

    // Called at posedge+1; drives one cycle, probes that din_ready ignores the
    // peer strobes, records handshake state and returns at the next posedge+1.
    task automatic step(input int g, input logic v, input logic [MW-1:0] d,
                        input logic r, input logic s);
        logic dr0;
        din_valid_a[g]  = v;
        din_a[g]        = d;
        dout_ready_a[g] = r;
        slip_a[g]       = s;
        #1;
        dr0 = dr_w[g];
        din_valid_a[g]  = ~v;
        dout_ready_a[g] = ~r;
        #1;
        chk($sformatf("g%0d_dr_indep", g), MW'(dr_w[g]), MW'(dr0));
        din_valid_a[g]  = v;
        dout_ready_a[g] = r;
        #1;
        last_dr  = dr_w[g];
        last_dv  = dv_w[g];
        last_acc = v & dr_w[g];
        @(posedge clk);
        #1;
        slip_a[g] = 1'b0;
    endtask

    initial begin
        arst_a       = 4'h0;
        din_valid_a  = 4'h0;
        dout_ready_a = 4'h0;
        slip_a       = 4'h0;
        for (int g = 0; g < 4; g++) din_a[g] = '0;
        #2;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("g%0d_rst_dv", g), MW'(dv_w[g]), MW'(0));
            chk($sformatf("g%0d_rst_dr", g), MW'(dr_w[g]), MW'(1));
            chk($sformatf("g%0d_rst_dout", g), dout_w[g], MW'(0));
        end
        #20 arst_a = 4'hF;
        @(posedge clk);
        #1;

        // 66 -> 32: 16 words stream out as exactly 33 words
        k = 0;
        for (int c = 0; c < 200 && k < 16; c++) begin
            step(0, 1'b1, pat(k), 1'b1, 1'b0);
            if (last_acc) k++;
        end
        chk("t1_words_in", MW'(k), MW'(16));
        for (int c = 0; c < 20 && g_dut[0].out_cnt < 33; c++) step(0, 1'b0, '0, 1'b1, 1'b0);
        chk("t1_outs", MW'(g_dut[0].out_cnt), MW'(33));
        chk("t1_left", MW'(g_dut[0].qsz), MW'(0));

        // 32 -> 66: handshake trace follows fill 0,32,64,96,30,62,94,28,60,92
        k = 0;
        for (int c = 0; c < 100 && k < 33; c++) begin
            step(1, 1'b1, pat(k + 50), 1'b1, 1'b0);
            if (c < 10) begin
                chk($sformatf("t2_dr_c%0d", c), MW'(last_dr), MW'(tr_dr2[c]));
                chk($sformatf("t2_dv_c%0d", c), MW'(last_dv), MW'(tr_dv2[c]));
            end
            if (last_acc) k++;
        end
        for (int c = 0; c < 20 && g_dut[1].out_cnt < 16; c++) step(1, 1'b0, '0, 1'b1, 1'b0);
        chk("t2_outs", MW'(g_dut[1].out_cnt), MW'(16));
        chk("t2_left", MW'(g_dut[1].qsz), MW'(0));

        // 8 -> 10: slip at c5 drops stream bit 30; the c6 slip arrives while pending
        k = 0;
        for (int c = 0; c < 200 && k < 20; c++) begin
            step(2, 1'b1, k[0] ? MW'(0) : MW'(8'hFF), 1'b1, (c == 5 || c == 6));
            if (last_acc) k++;
        end
        for (int c = 0; c < 20 && g_dut[2].out_cnt < 15; c++) step(2, 1'b0, '0, 1'b1, 1'b0);
        step(2, 1'b0, '0, 1'b1, 1'b0);
        chk("t3_outs", MW'(g_dut[2].out_cnt), MW'(15));
        chk("t3_left", MW'(g_dut[2].qsz), MW'(9));
        chk("t3_dv_end", MW'(dv_w[2]), MW'(0));

        // 66 -> 32 under random backpressure
        for (int c = 0; c < 300; c++)
            step(0, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 9) < 3), 1'b0);
        for (int c = 0; c < 10; c++) step(0, 1'b0, '0, 1'b1, 1'b0);
        chk("t4_dv_drained", MW'(dv_w[0]), MW'(g_dut[0].qsz >= 32));

        // Clean restart, build fill to 40, then reset mid-word
        arst_a[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        arst_a[0] = 1'b1;
        k = 0;
        for (int c = 0; c < 11; c++) begin
            step(0, 1'b1, pat(k + 100), 1'b1, 1'b0);
            if (last_acc) k++;
        end
        chk("t5_acc", MW'(k), MW'(4));
        din_valid_a[0] = 1'b0;
        chk("t5_pre_dv", MW'(dv_w[0]), MW'(1));
        chk("t5_pre_dr", MW'(dr_w[0]), MW'(0));
        #1 arst_a[0] = 1'b0;
        #1;
        chk("t5_rst_dv", MW'(dv_w[0]), MW'(0));
        chk("t5_rst_dr", MW'(dr_w[0]), MW'(1));
        chk("t5_rst_dout", dout_w[0], MW'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        arst_a[0] = 1'b1;
        base = g_dut[0].out_cnt;
        k = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            step(0, 1'b1, pat(k + 200), 1'b1, 1'b0);
            if (last_acc) k++;
        end
        for (int c = 0; c < 10; c++) step(0, 1'b0, '0, 1'b1, 1'b0);
        chk("t5_outs", MW'(g_dut[0].out_cnt - base), MW'(4));
        chk("t5_left", MW'(g_dut[0].qsz), MW'(4));

        // 40 -> 40: fill 0 then holds 40, one word in and out per cycle
        for (int c = 0; c < 8; c++) begin
            step(3, 1'b1, pat(c + 300), 1'b1, 1'b0);
            chk($sformatf("t6_dr_c%0d", c), MW'(last_dr), MW'(1));
            chk($sformatf("t6_dv_c%0d", c), MW'(last_dv), MW'(c > 0));
            chk($sformatf("t6_acc_c%0d", c), MW'(last_acc), MW'(1));
        end
        for (int c = 0; c < 3; c++) step(3, 1'b0, '0, 1'b1, 1'b0);
        chk("t6_outs", MW'(g_dut[3].out_cnt), MW'(8));
        chk("t6_left", MW'(g_dut[3].qsz), MW'(0));
        chk("t6_dv_end", MW'(dv_w[3]), MW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

endmodule
